alu_result_packer: RTL and testbench
====================================

// Module: alu_result_packer
// PURPOSE
//  Return-path collector for the TinyALU harness. Captures each {op, result}
//  pair on the ALU done strobe and packs the pairs into one wide packet.
//  The packet has the same 24-bit-slot layout the stimulus path uses, with
//  slot 0 in the LSBs.
//  The full packet is handed to the software side through a valid/ready
//  handshake; the testbench wrapper drains pkt_o into recv().
// PARAMETERS
//  RES_WIDTH   16    width of ALU result
//  OP_WIDTH    3     width of opcode tag
//  SLOT_WIDTH  24    bits per packed slot (RES_WIDTH+OP_WIDTH <= SLOT_WIDTH)
//  NUM_SLOTS   256   slots per packet
//  PKT_WIDTH   6144  SLOT_WIDTH*NUM_SLOTS
//  LEN_WIDTH   9     $clog2(NUM_SLOTS+1)
// PORTS
//  clk_i        in   1          clock, all logic on rising edge
//  reset_n      in   1          async active-low reset
//  done_i       in   1          ALU done strobe, one capture per cycle high
//  result_i     in   RES_WIDTH  ALU result, valid when done_i=1
//  op_i         in   OP_WIDTH   opcode of the completing operation
//  flush_i      in   1          close partial packet (1-cycle pulse)
//  pkt_o        out  PKT_WIDTH  packed packet
//  pkt_len_o    out  LEN_WIDTH  number of valid slots in pkt_o
//  pkt_valid_o  out  1          packet ready for consumer
//  pkt_ready_i  in   1          consumer accepts packet
//  drop_cnt_o   out  16         done strobes lost while in SEND (saturating)
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=FILL, count=0, pkt_o=0, pkt_len_o=0, pkt_valid_o=0, drop_cnt_o=0.
//   - Reset mid-packet discards the partial packet; nothing is emitted.
//  Slot format:
//   - slot k = pkt_o[k*SLOT_WIDTH +: SLOT_WIDTH].
//   - [RES_WIDTH-1:0]=result, [RES_WIDTH+OP_WIDTH-1:RES_WIDTH]=op, rest 0.
//   - Unwritten slots read 0.
//  FSM FILL:
//   - done_i=1: write slot[count], count<=count+1.
//   - done_i on count==NUM_SLOTS-1 (last slot): next cycle SEND,
//     pkt_valid_o=1, pkt_len_o=NUM_SLOTS.
//     Latency: last done edge -> valid 1 cycle.
//   - flush_i=1 with count>0: next cycle SEND, pkt_len_o=count.
//   - flush_i=1 with count==0: ignored.
//   - done_i and flush_i in the same cycle: the slot is written first, then
//     the packet closes; pkt_len_o includes the new slot.
//  FSM SEND:
//   - pkt_o and pkt_len_o are held stable while pkt_valid_o=1.
//   - pkt_valid_o&pkt_ready_i: next cycle FILL, pkt_valid_o=0, count=0,
//     pkt_o cleared to 0.
//   - done_i in SEND: sample discarded, drop_cnt_o+=1, saturates at 16'hFFFF.
//     This includes the accept cycle; the first capturable done is the cycle
//     after the state returns to FILL.
//   - flush_i in SEND: ignored.
//   - pkt_ready_i outside SEND: no effect.
//  count never exceeds NUM_SLOTS-1 in FILL; there is no wrap.
//  pkt_len_o is held until the next packet closes.
// TESTING
//  - Full packet:
//    256 done pulses with result=i*3, op=i%8, ready=1.
//    Expect one valid pulse one cycle after the 256th done, len=256.
//    Slot i = {5'b0, i%8, i*3}.
//  - Back-pressure:
//    Hold ready=0 for 20 cycles after valid, with 5 done pulses in that window.
//    Expect pkt_o stable, drop_cnt_o=5.
//    After ready=1, the next done lands in slot 0.
//  - Partial flush:
//    3 done pulses (0x1111/op1, 0x2222/op2, 0x3333/op3), then flush.
//    Expect len=3, slots 0..2 match, slots 3..255 = 0.
//  - Simultaneous done+flush:
//    done 0xABCD/op4 and flush on the same cycle, count=1.
//    Expect len=2, slot1=0x04ABCD.
//  - Empty flush:
//    flush with count=0 -> pkt_valid_o stays 0 for 10 cycles.
//  - Reset mid-fill:
//    After 100 done pulses, pulse reset_n low for 1 cycle.
//    Expect all outputs 0 immediately.
//    The next 256 done pulses form a clean packet starting at slot 0.

Source files
------------

// File: rtl/alu_result_packer_if.sv
// Bundle of the capture and packet-handshake signals between the TinyALU
// return path and the software-side consumer.
interface alu_result_packer_if #(
    parameter int RES_WIDTH  = 16,
    parameter int OP_WIDTH   = 3,
    parameter int SLOT_WIDTH = 24,
    parameter int NUM_SLOTS  = 256,
    parameter int PKT_WIDTH  = SLOT_WIDTH * NUM_SLOTS,
    parameter int LEN_WIDTH  = $clog2(NUM_SLOTS + 1)
);
    logic                 done_i;
    logic [RES_WIDTH-1:0] result_i;
    logic [OP_WIDTH-1:0]  op_i;
    logic                 flush_i;
    logic [PKT_WIDTH-1:0] pkt_o;
    logic [LEN_WIDTH-1:0] pkt_len_o;
    logic                 pkt_valid_o;
    logic                 pkt_ready_i;
    logic [15:0]          drop_cnt_o;

    // Producer/consumer side: drives ALU completions and accepts packets.
    modport master (
        output done_i, result_i, op_i, flush_i, pkt_ready_i,
        input  pkt_o, pkt_len_o, pkt_valid_o, drop_cnt_o
    );

    // Packer side.
    modport slave (
        input  done_i, result_i, op_i, flush_i, pkt_ready_i,
        output pkt_o, pkt_len_o, pkt_valid_o, drop_cnt_o
    );
endinterface

// File: rtl/alu_result_packer.sv
// Collects {op, result} pairs from the ALU done strobe into a wide packet of
// fixed-size slots (slot 0 in the LSBs) and hands the packet to a consumer
// over a valid/ready handshake. Completions arriving while a packet is
// waiting to be accepted are dropped and counted.
module alu_result_packer #(
    parameter int RES_WIDTH  = 16,
    parameter int OP_WIDTH   = 3,
    parameter int SLOT_WIDTH = 24,
    parameter int NUM_SLOTS  = 256,
    parameter int PKT_WIDTH  = SLOT_WIDTH * NUM_SLOTS,
    parameter int LEN_WIDTH  = $clog2(NUM_SLOTS + 1)
) (
    input logic               clk_i,
    input logic               reset_n,
    alu_result_packer_if.slave bus
);

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LAST_SLOT = LEN_WIDTH'(NUM_SLOTS - 1);

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [15:0]           drop_q, drop_d;
    logic                  wr_en;
    logic                  clr_pkt;
    logic [SLOT_WIDTH-1:0] slot_w;

    // Result in the low bits, opcode above it, remaining bits zero.
    assign slot_w = SLOT_WIDTH'({bus.op_i, bus.result_i});

    // Control state register; reset discards any partial packet.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
            count_q <= '0;
            len_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic: fill slots, close on last slot or flush, wait for accept.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        drop_d  = drop_q;
        wr_en   = 1'b0;
        clr_pkt = 1'b0;
        case (state_q)
            FILL: begin
                if (bus.done_i) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                end
                // A done in the same cycle as flush is written first, so it
                // counts toward the length and also makes an empty packet non-empty.
                if ((bus.done_i && count_q == LAST_SLOT) ||
                    (bus.flush_i && (count_q != '0 || bus.done_i))) begin
                    state_d = SEND;
                    len_d   = count_q + LEN_WIDTH'(bus.done_i);
                    count_d = '0;
                end
            end
            SEND: begin
                // Completions are lost here, including on the accept cycle.
                if (bus.done_i && drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
                if (bus.pkt_ready_i) begin
                    state_d = FILL;
                    clr_pkt = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // One register per slot with its own write decode, so a capture only
    // touches the addressed slot rather than shifting the whole packet.
    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        logic [SLOT_WIDTH-1:0] slot_q;

        // Slot storage: written on capture at its index, cleared on accept.
        always_ff @(posedge clk_i or negedge reset_n) begin
            if (!reset_n) begin
                slot_q <= '0;
            end else if (clr_pkt) begin
                slot_q <= '0;
            end else if (wr_en && count_q == LEN_WIDTH'(k)) begin
                slot_q <= slot_w;
            end
        end

        assign bus.pkt_o[k*SLOT_WIDTH +: SLOT_WIDTH] = slot_q;
    end

    assign bus.pkt_len_o   = len_q;
    assign bus.pkt_valid_o = (state_q == SEND);
    assign bus.drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_alu_result_packer.sv
// Directed bench for alu_result_packer: stimulus pushes expected packets
// into a scoreboard; a monitor pops and compares each presented packet.
module tb_alu_result_packer;
    localparam int RW = 16;
    localparam int OW = 3;
    localparam int SW = 24;
    localparam int NS = 256;
    localparam int PW = SW * NS;
    localparam int LW = 9;

    logic clk_i = 1'b0;
    logic reset_n = 1'b0;

    alu_result_packer_if #(.RES_WIDTH(RW), .OP_WIDTH(OW), .SLOT_WIDTH(SW),
                           .NUM_SLOTS(NS), .PKT_WIDTH(PW), .LEN_WIDTH(LW)) bus ();

    alu_result_packer #(.RES_WIDTH(RW), .OP_WIDTH(OW), .SLOT_WIDTH(SW),
                        .NUM_SLOTS(NS), .PKT_WIDTH(PW), .LEN_WIDTH(LW)) dut (
        .clk_i  (clk_i),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    logic [PW-1:0] exp_pkt_q[$];
    logic [LW-1:0] exp_len_q[$];
    logic [PW-1:0] exp_pkt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic chk_pkt(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            for (int s = 0; s < NS; s++) begin
                if (got[s*SW +: SW] !== exp[s*SW +: SW]) begin
                    $display("FAIL %s: slot %0d got 0x%06h expected 0x%06h",
                             name, s, got[s*SW +: SW], exp[s*SW +: SW]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [PW-1:0] put_slot(input logic [PW-1:0] p, input int k,
                                               input logic [15:0] res, input logic [2:0] op);
        logic [PW-1:0] r;
        r = p;
        r[k*SW +: SW] = {5'b0, op, res};
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input logic [PW-1:0] p, input logic [LW-1:0] l);
        exp_pkt_q.push_back(p);
        exp_len_q.push_back(l);
    endtask

    // Monitor: compare each packet once, on the first cycle it is presented.
    bit seen = 1'b0;
    always @(negedge clk_i) begin
        if (!reset_n) begin
            seen = 1'b0;
        end else if (bus.pkt_valid_o && !seen) begin
            seen = 1'b1;
            if (exp_pkt_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_packet: got len %0d expected no packet", bus.pkt_len_o);
            end else begin
                chk("mon_len", 32'(bus.pkt_len_o), 32'(exp_len_q.pop_front()));
                chk_pkt("mon_pkt", bus.pkt_o, exp_pkt_q.pop_front());
            end
        end else if (!bus.pkt_valid_o) begin
            seen = 1'b0;
        end
    end

    initial begin
        bus.done_i      = 1'b0;
        bus.result_i    = '0;
        bus.op_i        = '0;
        bus.flush_i     = 1'b0;
        bus.pkt_ready_i = 1'b1;
        repeat (2) cyc();
        chk("rst_valid", 32'(bus.pkt_valid_o), 32'd0);
        chk("rst_len", 32'(bus.pkt_len_o), 32'd0);
        chk("rst_drop", 32'(bus.drop_cnt_o), 32'd0);
        chk_pkt("rst_pkt", bus.pkt_o, '0);
        reset_n = 1'b1;
        cyc();

        // Full packet
        exp_pkt = '0;
        for (int i = 0; i < NS; i++) exp_pkt = put_slot(exp_pkt, i, 16'(i * 3), 3'(i % 8));
        push_exp(exp_pkt, 9'd256);
        for (int i = 0; i < NS; i++) begin
            chk("full_no_early_valid", 32'(bus.pkt_valid_o), 32'd0);
            bus.done_i = 1'b1; bus.result_i = 16'(i * 3); bus.op_i = 3'(i % 8);
            cyc();
        end
        bus.done_i = 1'b0;
        chk("full_valid_latency", 32'(bus.pkt_valid_o), 32'd1);
        chk("full_len", 32'(bus.pkt_len_o), 32'd256);
        cyc();
        chk("full_accepted", 32'(bus.pkt_valid_o), 32'd0);
        chk_pkt("full_cleared", bus.pkt_o, '0);
        chk("full_len_held", 32'(bus.pkt_len_o), 32'd256);

        // Back-pressure
        bus.pkt_ready_i = 1'b0;
        exp_pkt = put_slot('0, 0, 16'h0BAD, 3'd6);
        push_exp(exp_pkt, 9'd1);
        bus.done_i = 1'b1; bus.result_i = 16'h0BAD; bus.op_i = 3'd6;
        cyc();
        bus.done_i = 1'b0; bus.flush_i = 1'b1;
        cyc();
        bus.flush_i = 1'b0;
        chk("bp_valid", 32'(bus.pkt_valid_o), 32'd1);
        for (int i = 0; i < 20; i++) begin
            bus.done_i = (i % 4 == 0); bus.result_i = 16'hDEAD; bus.op_i = 3'd7;
            bus.flush_i = (i == 10);
            cyc();
            chk_pkt("bp_pkt_stable", bus.pkt_o, exp_pkt);
            chk("bp_len_stable", 32'(bus.pkt_len_o), 32'd1);
            chk("bp_valid_held", 32'(bus.pkt_valid_o), 32'd1);
        end
        bus.done_i = 1'b0; bus.flush_i = 1'b0;
        chk("bp_drop5", 32'(bus.drop_cnt_o), 32'd5);
        bus.pkt_ready_i = 1'b1; bus.done_i = 1'b1; bus.result_i = 16'hBEEF;
        cyc();
        bus.done_i = 1'b0;
        chk("bp_accept_drop", 32'(bus.drop_cnt_o), 32'd6);
        chk("bp_released", 32'(bus.pkt_valid_o), 32'd0);
        push_exp(put_slot('0, 0, 16'h5555, 3'd5), 9'd1);
        bus.done_i = 1'b1; bus.result_i = 16'h5555; bus.op_i = 3'd5;
        cyc();
        bus.done_i = 1'b0; bus.flush_i = 1'b1;
        cyc();
        bus.flush_i = 1'b0;
        chk("bp_next_slot0_valid", 32'(bus.pkt_valid_o), 32'd1);
        chk("bp_next_slot0", 32'(bus.pkt_o[23:0]), 32'h055555);
        cyc();

        // Partial flush
        exp_pkt = put_slot('0, 0, 16'h1111, 3'd1);
        exp_pkt = put_slot(exp_pkt, 1, 16'h2222, 3'd2);
        exp_pkt = put_slot(exp_pkt, 2, 16'h3333, 3'd3);
        push_exp(exp_pkt, 9'd3);
        for (int i = 1; i <= 3; i++) begin
            bus.done_i = 1'b1; bus.result_i = 16'(i * 16'h1111); bus.op_i = 3'(i);
            cyc();
        end
        bus.done_i = 1'b0; bus.flush_i = 1'b1;
        cyc();
        bus.flush_i = 1'b0;
        chk("partial_valid", 32'(bus.pkt_valid_o), 32'd1);
        chk("partial_len", 32'(bus.pkt_len_o), 32'd3);
        cyc();

        // Simultaneous done + flush
        exp_pkt = put_slot('0, 0, 16'h1234, 3'd2);
        exp_pkt = put_slot(exp_pkt, 1, 16'hABCD, 3'd4);
        push_exp(exp_pkt, 9'd2);
        bus.done_i = 1'b1; bus.result_i = 16'h1234; bus.op_i = 3'd2;
        cyc();
        bus.result_i = 16'hABCD; bus.op_i = 3'd4; bus.flush_i = 1'b1;
        cyc();
        bus.done_i = 1'b0; bus.flush_i = 1'b0;
        chk("simul_valid", 32'(bus.pkt_valid_o), 32'd1);
        chk("simul_len", 32'(bus.pkt_len_o), 32'd2);
        chk("simul_slot1", 32'(bus.pkt_o[47:24]), 32'h04ABCD);
        cyc();

        // Empty flush
        bus.flush_i = 1'b1;
        cyc();
        bus.flush_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("empty_flush_no_valid", 32'(bus.pkt_valid_o), 32'd0);
            cyc();
        end

        // Reset mid-fill
        for (int i = 0; i < 100; i++) begin
            bus.done_i = 1'b1; bus.result_i = 16'(i + 16'h4000); bus.op_i = 3'(i % 8);
            cyc();
        end
        bus.done_i = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.pkt_valid_o), 32'd0);
        chk("midrst_len", 32'(bus.pkt_len_o), 32'd0);
        chk("midrst_drop", 32'(bus.drop_cnt_o), 32'd0);
        chk_pkt("midrst_pkt", bus.pkt_o, '0);
        @(posedge clk_i);
        #2;
        reset_n = 1'b1;
        cyc();
        exp_pkt = '0;
        for (int i = 0; i < NS; i++) exp_pkt = put_slot(exp_pkt, i, 16'hFFFF - 16'(i * 7), 3'((i + 3) % 8));
        push_exp(exp_pkt, 9'd256);
        for (int i = 0; i < NS; i++) begin
            bus.done_i = 1'b1; bus.result_i = 16'hFFFF - 16'(i * 7); bus.op_i = 3'((i + 3) % 8);
            cyc();
        end
        bus.done_i = 1'b0;
        chk("post_rst_valid", 32'(bus.pkt_valid_o), 32'd1);
        chk("post_rst_len", 32'(bus.pkt_len_o), 32'd256);
        repeat (4) cyc();
        chk("scoreboard_drained", 32'(exp_pkt_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
